// File: rtl/oam_dma_ctrl.sv
// FF46 OAM DMA sequencer: latches a source page on a write to FF46, then copies
// BYTES bytes from {page, idx} into OAM, one byte per CYC_PER_BYTE-clock slot.
module oam_dma_ctrl #(
  parameter int BYTES        = 160,
  parameter int CYC_PER_BYTE = 4,
  parameter int START_DLY    = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ffxx_i,
  input  logic [7:0]  a_lo_i,
  input  logic        cpu_wr_i,
  input  logic        cpu_rd_i,
  input  logic [7:0]  d_in_i,
  output logic [7:0]  ff46_q_o,
  output logic        ff46_oe_o,
  output logic        dma_busy_o,
  output logic        bus_req_o,
  output logic        cpu_block_o,
  output logic [15:0] dma_addr_o,
  output logic        dma_rd_o,
  input  logic [7:0]  dma_din_i,
  output logic [7:0]  oam_addr_o,
  output logic [7:0]  oam_data_o,
  output logic        oam_we_o
);

  // state  | meaning
  // IDLE   | no transfer, CPU owns the bus
  // START  | page latched, counting down START_DLY clocks before taking the bus
  // XFER   | DMA owns the bus, one byte per slot of CYC_PER_BYTE clocks

  localparam int PW = (CYC_PER_BYTE > 1) ? $clog2(CYC_PER_BYTE) : 1;
  localparam int CW = (START_DLY > 1) ? $clog2(START_DLY) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_XFER  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    idx_q, idx_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [7:0]    src_page_q, src_page_d;
  logic [7:0]    ff46_reg_q, ff46_reg_d;

  logic wr46;
  logic slot_end;
  logic last_byte;
  logic bus_req;

  assign wr46      = ffxx_i && (a_lo_i == 8'h46) && cpu_wr_i;
  assign slot_end  = (state_q == S_XFER) && (phase_q == PW'(CYC_PER_BYTE - 1));
  assign last_byte = (idx_q == 8'(BYTES - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      phase_q    <= '0;
      src_page_q <= '0;
      ff46_reg_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      src_page_q <= src_page_d;
      ff46_reg_q <= ff46_reg_d;
    end
  end

  // A new FF46 write always wins, including over the last-byte return to IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    phase_d    = phase_q;
    src_page_d = src_page_q;
    ff46_reg_d = ff46_reg_q;
    if (wr46) begin
      ff46_reg_d = d_in_i;
      src_page_d = (d_in_i < 8'hE0) ? d_in_i : (d_in_i - 8'h20);
      state_d    = S_START;
      cnt_d      = CW'(START_DLY - 1);
      idx_d      = '0;
      phase_d    = '0;
    end else begin
      unique case (state_q)
        S_START: begin
          if (cnt_q == '0) begin
            state_d = S_XFER;
            phase_d = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_XFER: begin
          if (slot_end) begin
            phase_d = '0;
            if (last_byte) begin
              state_d = S_IDLE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 8'd1;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A slot cut short by a restart never writes OAM.
  always_comb begin
    dma_busy_o = 1'b0;
    bus_req    = 1'b0;
    dma_rd_o   = 1'b0;
    dma_addr_o = '0;
    oam_addr_o = '0;
    oam_data_o = '0;
    oam_we_o   = 1'b0;
    unique case (state_q)
      S_START: dma_busy_o = 1'b1;
      S_XFER: begin
        dma_busy_o = 1'b1;
        bus_req    = 1'b1;
        dma_rd_o   = 1'b1;
        dma_addr_o = {src_page_q, idx_q};
        oam_addr_o = idx_q;
        if (slot_end && !wr46) begin
          oam_we_o   = 1'b1;
          oam_data_o = dma_din_i;
        end
      end
      default: ;
    endcase
  end

  assign bus_req_o   = bus_req;
  assign cpu_block_o = bus_req && !ffxx_i;
  assign ff46_q_o    = ff46_reg_q;
  assign ff46_oe_o   = ffxx_i && (a_lo_i == 8'h46) && cpu_rd_i;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: a timeline model predicts every OAM write
// and the busy/bus windows; a negedge monitor compares against the DUT.
module tb_oam_dma_ctrl;

  localparam int unsigned BYTES = 160;
  localparam int unsigned CPB   = 4;
  localparam int unsigned SD    = 4;
  localparam int unsigned XLEN  = SD + BYTES * CPB;

  logic        clk = 1'b0;
  logic        reset;
  logic        ffxx;
  logic [7:0]  a_lo;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  d_in;
  logic [7:0]  ff46_q;
  logic        ff46_oe;
  logic        dma_busy;
  logic        bus_req;
  logic        cpu_block;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic [7:0]  dma_din;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        oam_we;

  always #5 clk = ~clk;

  oam_dma_ctrl #(.BYTES(160), .CYC_PER_BYTE(4), .START_DLY(4)) dut (
    .clk_i(clk), .reset_i(reset), .ffxx_i(ffxx), .a_lo_i(a_lo),
    .cpu_wr_i(cpu_wr), .cpu_rd_i(cpu_rd), .d_in_i(d_in),
    .ff46_q_o(ff46_q), .ff46_oe_o(ff46_oe), .dma_busy_o(dma_busy),
    .bus_req_o(bus_req), .cpu_block_o(cpu_block), .dma_addr_o(dma_addr),
    .dma_rd_o(dma_rd), .dma_din_i(dma_din), .oam_addr_o(oam_addr),
    .oam_data_o(oam_data), .oam_we_o(oam_we)
  );

  // Source memory: content depends on both page and offset.
  assign dma_din = dma_addr[7:0] ^ dma_addr[15:8];

  typedef struct {
    int unsigned cyc;
    logic [7:0]  addr;
    logic [7:0]  data;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          chk_en = 1'b0;

  bit          m_active = 1'b0;
  int unsigned m_wr = 0;
  logic [7:0]  m_page = 8'h00;
  logic [7:0]  m_ff46 = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mirror(input logic [7:0] d);
    return (d >= 8'hE0) ? d - 8'h20 : d;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  int unsigned mc;
  bit          m_busy_e, m_bus_e, m_we_e;
  logic [15:0] m_addr_e;

  always @(negedge clk) begin
    if (chk_en) begin
      mc       = cyc;
      m_busy_e = m_active && (mc >= m_wr) && (mc < m_wr + XLEN);
      m_bus_e  = m_active && (mc >= m_wr + SD) && (mc < m_wr + XLEN);
      m_addr_e = m_bus_e ? {m_page, 8'((mc - m_wr - SD) / CPB)} : 16'h0000;
      chk("dma_busy", 16'(dma_busy), 16'(m_busy_e));
      chk("bus_req", 16'(bus_req), 16'(m_bus_e));
      chk("dma_rd", 16'(dma_rd), 16'(m_bus_e));
      chk("dma_addr", dma_addr, m_addr_e);
      chk("cpu_block", 16'(cpu_block), 16'(m_bus_e && !ffxx));
      chk("ff46_q", 16'(ff46_q), 16'(m_ff46));
      chk("ff46_oe", 16'(ff46_oe), 16'(ffxx && (a_lo == 8'h46) && cpu_rd));
      m_we_e = (sb_q.size() > 0) && (sb_q[0].cyc == mc);
      chk("oam_we", 16'(oam_we), 16'(m_we_e));
      if (oam_we && m_we_e) begin
        chk("oam_addr", 16'(oam_addr), 16'(sb_q[0].addr));
        chk("oam_data", 16'(oam_data), 16'(sb_q[0].data));
      end
      while (sb_q.size() > 0 && sb_q[0].cyc <= mc) void'(sb_q.pop_front());
    end
  end

  task automatic noise();
    ffxx = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0:       a_lo = 8'h46;
      1:       a_lo = 8'h80;
      default: a_lo = 8'($urandom);
    endcase
    cpu_rd = 1'($urandom_range(0, 1));
    cpu_wr = 1'($urandom_range(0, 1));
    if (ffxx && a_lo == 8'h46) cpu_wr = 1'b0;
    d_in = 8'($urandom);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      noise();
    end
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) step(1);
  endtask

  task automatic flush_from(input int unsigned lim);
    while (sb_q.size() > 0 && sb_q[sb_q.size()-1].cyc >= lim) void'(sb_q.pop_back());
  endtask

  task automatic trig(input logic [7:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    ffxx = 1'b1; a_lo = 8'h46; cpu_wr = 1'b1; cpu_rd = 1'b0; d_in = d;
    flush_from(cyc);
    @(posedge clk);
    #1;
    noise();
    m_active = 1'b1;
    m_wr     = cyc;
    m_page   = mirror(d);
    m_ff46   = d;
    for (int k = 0; k < int'(BYTES); k++) begin
      e.cyc  = m_wr + SD + CPB - 1 + int'(k) * CPB;
      e.addr = 8'(k);
      e.data = 8'(k) ^ m_page;
      sb_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    flush_from(cyc + 1);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    m_active = 1'b0;
    m_ff46   = 8'h00;
    noise();
  endtask

  task automatic wait_done();
    wait_until(m_wr + XLEN + 3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  logic [7:0] corner[4];

  initial begin
    reset = 1'b1; ffxx = 1'b0; a_lo = 8'h00; cpu_wr = 1'b0; cpu_rd = 1'b0; d_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    step(5);

    trig(8'hC1);
    wait_done();

    trig(8'hFE);
    wait_done();

    trig(8'h80);
    wait_until(m_wr + SD + 50 * CPB + $urandom_range(0, 3) - 1);
    trig(8'h90);
    wait_done();

    trig(8'($urandom));
    wait_until(m_wr + SD + 20 * CPB + $urandom_range(0, 3) - 1);
    do_reset();
    step(3);
    trig(8'($urandom));
    wait_done();

    trig(8'h3C);
    wait_until(m_wr + XLEN - 2);
    trig(8'hE7);
    wait_done();

    corner[0] = 8'hDF; corner[1] = 8'hE0; corner[2] = 8'hFF; corner[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      trig(corner[i]);
      step($urandom_range(1, 700));
    end
    wait_done();

    for (int i = 0; i < 6; i++) begin
      trig(8'($urandom));
      step($urandom_range(0, 400));
    end
    wait_done();
    step(4);

    chk("sb_empty", 16'(sb_q.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
